// File: rtl/gpu_bus_interface.sv
// gpu_bus_interface: CPU write port that builds a 16-bit GPU memory pointer and strobes tile/attribute/color RAM writes.
// Bus inputs are synchronised through two flops; each synchronised cs_clock fall is one transaction.
module gpu_bus_interface (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  data,
    input  logic [2:0]  addr,
    input  logic        rw,
    input  logic        cs_clock,
    output logic        tile_memory_write_enable,
    output logic [10:0] tile_memory_write_addr,
    output logic [7:0]  tile_memory_write_data,
    output logic        attribute_memory_write_enable,
    output logic [11:0] attribute_memory_write_addr,
    output logic [7:0]  attribute_memory_write_data,
    output logic        color_memory_write_enable,
    output logic [3:0]  color_memory_write_addr,
    output logic [7:0]  color_memory_write_data
);
    logic        cs1_q, cs2_q, cs3_q, rw1_q, rw2_q;
    logic [2:0]  a1_q, a2_q, fill_q;
    logic [7:0]  d1_q, d2_q;
    logic [15:0] ptr_q, ptr_d;
    logic        tile_we_q, tile_we_d, attr_we_q, attr_we_d, color_we_q, color_we_d;
    logic [10:0] tile_a_q;
    logic [11:0] attr_a_q;
    logic [3:0]  color_a_q;
    logic [7:0]  tile_d_q, attr_d_q, color_d_q;
    logic        txn, wr, tile_hit, attr_hit, color_hit;

    // fill_q[2] marks cs3_q as a genuinely sampled value, so a low held across reset is never taken as a fresh edge
    always_comb begin
        txn        = fill_q[2] & cs3_q & ~cs2_q & ~rw2_q;
        wr         = txn && a2_q == 3'd6;
        tile_hit   = ptr_q < 16'h0800;
        attr_hit   = !tile_hit && ptr_q < 16'h1800;
        color_hit  = ptr_q[15:4] == 12'h180;
        tile_we_d  = wr & tile_hit;
        attr_we_d  = wr & attr_hit;
        color_we_d = wr & color_hit;
        ptr_d      = !txn         ? ptr_q :
                     a2_q == 3'd4 ? {ptr_q[15:8], d2_q} :
                     a2_q == 3'd5 ? {d2_q, ptr_q[7:0]} :
                     a2_q == 3'd6 ? ptr_q + 16'd1 : ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {cs1_q, cs2_q, cs3_q} <= 3'b111;
            {rw1_q, rw2_q}        <= 2'b11;
            {a1_q, a2_q}          <= '0;
            {d1_q, d2_q}          <= '0;
            fill_q                <= '0;
            ptr_q                 <= '0;
            tile_we_q             <= 1'b0;
            attr_we_q             <= 1'b0;
            color_we_q            <= 1'b0;
            tile_a_q              <= '0;
            attr_a_q              <= '0;
            color_a_q             <= '0;
            tile_d_q              <= '0;
            attr_d_q              <= '0;
            color_d_q             <= '0;
        end else begin
            {cs1_q, cs2_q, cs3_q} <= {cs_clock, cs1_q, cs2_q};
            {rw1_q, rw2_q}        <= {rw, rw1_q};
            {a1_q, a2_q}          <= {addr, a1_q};
            {d1_q, d2_q}          <= {data, d1_q};
            fill_q                <= {fill_q[1:0], 1'b1};
            ptr_q                 <= ptr_d;
            tile_we_q             <= tile_we_d;
            attr_we_q             <= attr_we_d;
            color_we_q            <= color_we_d;
            tile_a_q              <= tile_we_d ? ptr_q[10:0] : tile_a_q;
            tile_d_q              <= tile_we_d ? d2_q : tile_d_q;
            attr_a_q              <= attr_we_d ? ptr_q[11:0] - 12'h800 : attr_a_q;
            attr_d_q              <= attr_we_d ? d2_q : attr_d_q;
            color_a_q             <= color_we_d ? ptr_q[3:0] : color_a_q;
            color_d_q             <= color_we_d ? d2_q : color_d_q;
        end
    end

    assign tile_memory_write_enable      = tile_we_q;
    assign tile_memory_write_addr        = tile_a_q;
    assign tile_memory_write_data        = tile_d_q;
    assign attribute_memory_write_enable = attr_we_q;
    assign attribute_memory_write_addr   = attr_a_q;
    assign attribute_memory_write_data   = attr_d_q;
    assign color_memory_write_enable     = color_we_q;
    assign color_memory_write_addr       = color_a_q;
    assign color_memory_write_data       = color_d_q;
endmodule

// File: tb/tb_gpu_bus_interface.sv
// tb_gpu_bus_interface: randomized and directed bus writes checked against a pointer/region model of the GPU register port.
module tb_gpu_bus_interface;
    logic        clk = 1'b0, reset_n = 1'b0, rw = 1'b1, cs_clock = 1'b1;
    logic [7:0]  data = '0;
    logic [2:0]  addr = '0;
    logic        tile_en, attr_en, color_en;
    logic [10:0] tile_a;
    logic [11:0] attr_a;
    logic [3:0]  color_a;
    logic [7:0]  tile_d, attr_d, color_d;

    typedef struct packed {
        logic [1:0]  id;
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t  exp_q[$];
    int   checks = 0, errors = 0, strobes = 0, pushed = 0, cyc = 0, tx_cyc = 0, last_cyc = -1;
    int   ptr = 0;
    logic [7:0]  tile_ram [2048];
    logic [7:0]  attr_ram [4096];
    logic [7:0]  color_ram [16];
    logic [10:0] last_ta;
    logic [11:0] last_aa;
    logic [3:0]  last_ca;
    logic [7:0]  last_td, last_ad, last_cd;

    gpu_bus_interface dut (
        .clk(clk), .reset_n(reset_n), .data(data), .addr(addr), .rw(rw), .cs_clock(cs_clock),
        .tile_memory_write_enable(tile_en), .tile_memory_write_addr(tile_a), .tile_memory_write_data(tile_d),
        .attribute_memory_write_enable(attr_en), .attribute_memory_write_addr(attr_a), .attribute_memory_write_data(attr_d),
        .color_memory_write_enable(color_en), .color_memory_write_addr(color_a), .color_memory_write_data(color_d)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Observes strobes, matches them in order against the model, mirrors the RAMs and checks output hold
    always @(negedge clk) begin
        wr_t o, e;
        if (!reset_n) begin
            last_ta = '0; last_aa = '0; last_ca = '0;
            last_td = '0; last_ad = '0; last_cd = '0;
        end else begin
            checks++;
            if (int'(tile_en) + int'(attr_en) + int'(color_en) > 1) begin
                errors++;
                $display("FAIL onehot: enables t/a/c=%b%b%b required at most one", tile_en, attr_en, color_en);
            end
            if (tile_en || attr_en || color_en) begin
                strobes++;
                last_cyc = cyc;
                o = tile_en ? wr_t'{2'd0, {1'b0, tile_a}, tile_d} :
                    attr_en ? wr_t'{2'd1, attr_a, attr_d} : wr_t'{2'd2, {8'd0, color_a}, color_d};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_strobe: ram=%0d addr=%h data=%h required no strobe", o.id, o.a, o.d);
                end else begin
                    e = exp_q.pop_front();
                    if (o !== e) begin
                        errors++;
                        $display("FAIL strobe: ram=%0d addr=%h data=%h required ram=%0d addr=%h data=%h",
                                 o.id, o.a, o.d, e.id, e.a, e.d);
                    end
                end
                if (tile_en)  begin tile_ram[tile_a] = tile_d;    last_ta = tile_a;  last_td = tile_d;  end
                if (attr_en)  begin attr_ram[attr_a] = attr_d;    last_aa = attr_a;  last_ad = attr_d;  end
                if (color_en) begin color_ram[color_a] = color_d; last_ca = color_a; last_cd = color_d; end
            end
            checks++;
            if ({tile_a, tile_d, attr_a, attr_d, color_a, color_d} !==
                {last_ta, last_td, last_aa, last_ad, last_ca, last_cd}) begin
                errors++;
                $display("FAIL hold: t=%h/%h a=%h/%h c=%h/%h required t=%h/%h a=%h/%h c=%h/%h",
                         tile_a, tile_d, attr_a, attr_d, color_a, color_d,
                         last_ta, last_td, last_aa, last_ad, last_ca, last_cd);
            end
        end
    end

    task automatic model(input logic [2:0] a, input logic [7:0] d, input logic r);
        wr_t e;
        if (r) return;
        if (a == 3'd4) ptr = (ptr & 'hFF00) | int'(d);
        else if (a == 3'd5) ptr = (ptr & 'h00FF) | (int'(d) << 8);
        else if (a == 3'd6) begin
            e.d = d;
            if (ptr < 'h0800)      begin e.id = 2'd0; e.a = 12'(ptr);          exp_q.push_back(e); pushed++; end
            else if (ptr < 'h1800) begin e.id = 2'd1; e.a = 12'(ptr - 'h0800); exp_q.push_back(e); pushed++; end
            else if (ptr < 'h1810) begin e.id = 2'd2; e.a = 12'(ptr - 'h1800); exp_q.push_back(e); pushed++; end
            ptr = (ptr + 1) % 65536;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input logic r, input int lo, input int hi);
        model(a, d, r);
        addr = a; data = d; rw = r; cs_clock = 1'b0;
        tx_cyc = cyc + 1;
        repeat (lo) @(negedge clk);
        cs_clock = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    task automatic set_ptr(input int p);
        bus_write(3'd4, 8'(p), 1'b0, 2, 2);
        bus_write(3'd5, 8'(p >> 8), 1'b0, 2, 2);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tile_en, attr_en, color_en} !== 3'b000) begin
            errors++; $display("FAIL reset_en: %b required 000", {tile_en, attr_en, color_en});
        end
        checks++;
        if ({tile_a, tile_d, attr_a, attr_d} !== 39'd0) begin
            errors++; $display("FAIL reset_ta: %h %h %h %h required zero", tile_a, tile_d, attr_a, attr_d);
        end
        checks++;
        if ({color_a, color_d} !== 12'd0) begin
            errors++; $display("FAIL reset_color: %h %h required zero", color_a, color_d);
        end
        reset_n = 1'b1;
        ptr = 0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        int s0 = strobes, p0 = pushed;
        set_ptr('h0100); bus_write(3'd6, 8'hAA, 1'b0, 2, 3);
        set_ptr('h0900); bus_write(3'd6, 8'h0E, 1'b0, 2, 3);
        set_ptr('h1802); bus_write(3'd6, 8'hBE, 1'b0, 2, 3);
        repeat (4) @(negedge clk);
        checks++;
        if (tile_ram[11'h100] !== 8'hAA) begin errors++; $display("FAIL tile_read: %h required aa", tile_ram[11'h100]); end
        checks++;
        if (attr_ram[12'h100] !== 8'h0E) begin errors++; $display("FAIL attr_read: %h required 0e", attr_ram[12'h100]); end
        checks++;
        if (color_ram[2] !== 8'hBE) begin errors++; $display("FAIL color_read: %h required be", color_ram[2]); end
        checks++;
        if (strobes - s0 !== pushed - p0 || exp_q.size() != 0) begin
            errors++; $display("FAIL basic_count: %0d strobes required %0d", strobes - s0, pushed - p0);
        end
    endtask

    task automatic test_boundaries();
        int s0 = strobes, p0 = pushed;
        int bp[5] = '{'h07FF, 'h0800, 'h17FF, 'h180F, 'h1810};
        foreach (bp[i]) begin set_ptr(bp[i]); bus_write(3'd6, 8'($urandom), 1'b0, 2, 2); end
        set_ptr('h07FF);
        bus_write(3'd6, 8'h11, 1'b0, 2, 2);
        bus_write(3'd6, 8'h22, 1'b0, 2, 2);
        bus_write(3'd6, 8'h33, 1'b0, 2, 2);
        set_ptr('hFFFF);
        bus_write(3'd6, 8'h44, 1'b0, 2, 2);
        bus_write(3'd6, 8'h55, 1'b0, 2, 2);
        repeat (4) @(negedge clk);
        checks++;
        if ({tile_ram[11'h7FF], attr_ram[0], attr_ram[1]} !== 24'h112233) begin
            errors++; $display("FAIL span: %h %h %h required 11 22 33", tile_ram[11'h7FF], attr_ram[0], attr_ram[1]);
        end
        checks++;
        if (tile_ram[0] !== 8'h55) begin errors++; $display("FAIL wrap: tile[0]=%h required 55", tile_ram[0]); end
        checks++;
        if (strobes - s0 !== pushed - p0 || exp_q.size() != 0) begin
            errors++; $display("FAIL boundary_count: %0d strobes required %0d", strobes - s0, pushed - p0);
        end
    endtask

    task automatic test_ignored();
        int s0 = strobes, p0 = pushed;
        set_ptr('h0123);
        bus_write(3'd6, 8'h99, 1'b1, 2, 2);
        for (int a = 0; a < 8; a++) if (a < 4 || a == 7) bus_write(3'(a), 8'($urandom), 1'b0, 2, 2);
        bus_write(3'd4, 8'h77, 1'b1, 2, 2);
        repeat (4) @(negedge clk);
        checks++;
        if (strobes != s0) begin errors++; $display("FAIL ignored: %0d strobes required 0", strobes - s0); end
        bus_write(3'd6, 8'h66, 1'b0, 2, 2);
        repeat (4) @(negedge clk);
        checks++;
        if (tile_ram[11'h123] !== 8'h66 || strobes - s0 !== pushed - p0) begin
            errors++; $display("FAIL ptr_kept: tile[123]=%h required 66", tile_ram[11'h123]);
        end
    endtask

    task automatic test_long_pulse();
        int s0 = strobes;
        set_ptr('h0200);
        s0 = strobes;
        bus_write(3'd6, 8'h5A, 1'b0, 10, 3);
        repeat (4) @(negedge clk);
        checks++;
        if (strobes - s0 != 1) begin errors++; $display("FAIL long_pulse: %0d strobes required 1", strobes - s0); end
    endtask

    task automatic test_latency();
        set_ptr('h0300);
        bus_write(3'd6, 8'hC3, 1'b0, 2, 4);
        checks++;
        if (last_cyc != tx_cyc + 2) begin
            errors++; $display("FAIL latency: strobe at edge %0d required %0d", last_cyc, tx_cyc + 2);
        end
    endtask

    task automatic test_mid_reset();
        int s0 = strobes;
        set_ptr('h0400);
        s0 = strobes;
        addr = 3'd6; data = 8'h5E; rw = 1'b0; cs_clock = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        ptr = 0;
        repeat (2) @(negedge clk);
        cs_clock = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (strobes != s0) begin errors++; $display("FAIL mid_reset: %0d strobes required 0", strobes - s0); end
        bus_write(3'd6, 8'h77, 1'b0, 2, 2);
        repeat (4) @(negedge clk);
        checks++;
        if (tile_ram[0] !== 8'h77 || strobes - s0 != 1) begin
            errors++; $display("FAIL post_reset: tile[0]=%h strobes=%0d required 77 and 1", tile_ram[0], strobes - s0);
        end
    endtask

    task automatic test_back_to_back();
        int s0 = strobes, p0 = pushed;
        set_ptr('h17FC);
        for (int i = 0; i < 8; i++) bus_write(3'd6, 8'(i * 17 + 3), 1'b0, 2, 2);
        repeat (4) @(negedge clk);
        checks++;
        if (strobes - s0 !== pushed - p0 || exp_q.size() != 0) begin
            errors++; $display("FAIL back_to_back: %0d strobes required %0d", strobes - s0, pushed - p0);
        end
    endtask

    task automatic test_random();
        int s0 = strobes, p0 = pushed;
        logic [2:0] a;
        logic [7:0] d;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 5))
                0: a = 3'd4;
                1: a = 3'd5;
                5: a = 3'($urandom);
                default: a = 3'd6;
            endcase
            d = (a == 3'd5) ? (($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8'h18))) : 8'($urandom);
            bus_write(a, d, $urandom_range(0, 7) == 0, $urandom_range(2, 5), $urandom_range(2, 4));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (strobes - s0 !== pushed - p0 || exp_q.size() != 0) begin
            errors++; $display("FAIL random_count: %0d strobes required %0d", strobes - s0, pushed - p0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_boundaries();
        test_ignored();
        test_long_pulse();
        test_latency();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
